// File: rtl/tlu_fifo_arbiter.sv
// Merges N first-word-fall-through source FIFOs into one registered DW-bit readout stream.
// Optional build macro TLU_ARB_SRC_TAG_EN adds OUT_SRC, the source index of the word in OUT_DATA.
module tlu_fifo_arbiter #(
  parameter int N_SRC     = 4,
  parameter int MAX_BURST = 16,
  parameter int DW        = 32,
  localparam int IW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST_N,
  input  logic                  ENABLE,
  input  logic [N_SRC-1:0]      SRC_EMPTY,
  input  logic [N_SRC*DW-1:0]   SRC_DATA,
  input  logic [N_SRC-1:0]      SRC_PREEMPT_REQ,
  output logic [N_SRC-1:0]      SRC_READ,
  output logic                  OUT_VALID,
  output logic [DW-1:0]         OUT_DATA,
  input  logic                  OUT_READY,
  output logic [IW-1:0]         GRANT_IDX,
  output logic                  BUSY,
`ifdef TLU_ARB_SRC_TAG_EN
  output logic [IW-1:0]         OUT_SRC,
`endif
  output logic                  DBG_STATE
);

  // Handshake: a word moves to the sink in any cycle where OUT_VALID && OUT_READY;
  // a source word is popped in any cycle where its SRC_READ bit is high (FWFT head consumed).
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [8:0] MAXB = 9'(MAX_BURST);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_grant;
  logic [7:0]       r_cnt;
  logic             r_valid;
  logic [DW-1:0]    r_data;

  logic             w_any;
  logic             w_pre_hit;
  logic [IW-1:0]    w_pre_idx;
  logic [IW-1:0]    w_rr_idx;
  logic [IW-1:0]    w_sel_idx;
  logic             w_other_pre;
  logic             w_pre_g;
  logic             w_empty_g;
  logic             w_can_load;
  logic             w_cap_now;
  logic             w_cap_next;
  logic             w_rel_now;
  logic             w_pop;
  logic [N_SRC-1:0] w_read;
  logic [DW-1:0]    w_src_word;

  assign w_any      = |(~SRC_EMPTY);
  assign w_pre_g    = SRC_PREEMPT_REQ[r_grant];
  assign w_empty_g  = SRC_EMPTY[r_grant];
  assign w_can_load = !r_valid || OUT_READY;
  assign w_src_word = SRC_DATA[r_grant*DW +: DW];
  assign w_sel_idx  = w_pre_hit ? w_pre_idx : w_rr_idx;

  // Descending scans so the lowest preempt index and the nearest round-robin successor win.
  always_comb begin
    w_pre_hit   = 1'b0;
    w_pre_idx   = '0;
    w_rr_idx    = r_grant;
    w_other_pre = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (SRC_PREEMPT_REQ[i] && !SRC_EMPTY[i]) begin
        w_pre_hit = 1'b1;
        w_pre_idx = IW'(i);
        if (IW'(i) != r_grant) w_other_pre = 1'b1;
      end
    end
    for (int k = N_SRC; k >= 1; k--) begin
      if (!SRC_EMPTY[(int'(r_grant) + k) % N_SRC]) w_rr_idx = IW'((int'(r_grant) + k) % N_SRC);
    end
  end

  // A preempting owner ignores both the burst cap and other requesters.
  assign w_cap_now  = ({1'b0, r_cnt} >= MAXB) && !w_pre_g;
  assign w_cap_next = (({1'b0, r_cnt} + 9'd1) >= MAXB) && !w_pre_g;
  assign w_rel_now  = w_empty_g || !ENABLE || (w_other_pre && !w_pre_g) || w_cap_now;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_read      = '0;
    case (r_state)
      S_IDLE: begin
        if (ENABLE && w_any) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        if (w_rel_now) begin
          w_state_nxt = S_IDLE;
        end else if (w_can_load) begin
          w_pop = 1'b1;
          if (w_cap_next) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_read[r_grant] = w_pop;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_state <= S_IDLE;
      r_grant <= IW'(N_SRC - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (w_state_nxt == S_GRANT) r_grant <= w_sel_idx;
      end else if (w_pop && ({1'b0, r_cnt} < MAXB)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data  <= w_src_word;
    end else if (OUT_READY) begin
      r_valid <= 1'b0;
    end
  end

`ifdef TLU_ARB_SRC_TAG_EN
  logic [IW-1:0] r_src;
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)  r_src <= '0;
    else if (w_pop)  r_src <= r_grant;
  end
  assign OUT_SRC = r_src;
`else
  // Untagged build: OUT_DATA carries the raw source word and nothing else.
`endif

  assign SRC_READ  = w_read;
  assign OUT_VALID = r_valid;
  assign OUT_DATA  = r_data;
  assign GRANT_IDX = r_grant;
  assign BUSY      = (r_state != S_IDLE) || r_valid;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_tlu_fifo_arbiter.sv
// Directed bench for tlu_fifo_arbiter (N_SRC=4, MAX_BURST=4): source FIFOs are bench queues,
// accepted words are collected and compared against a per-test expected queue.
module tb_tlu_fifo_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            BUS_CLK = 1'b0;
  logic            BUS_RST_N = 1'b0;
  logic            ENABLE = 1'b0;
  logic [N-1:0]    SRC_EMPTY = '1;
  logic [N*DW-1:0] SRC_DATA = '0;
  logic [N-1:0]    SRC_PREEMPT_REQ = '0;
  logic [N-1:0]    SRC_READ;
  logic            OUT_VALID;
  logic [DW-1:0]   OUT_DATA;
  logic            OUT_READY = 1'b1;
  logic [1:0]      GRANT_IDX;
  logic            BUSY;
  logic            DBG_STATE;
`ifdef TLU_ARB_SRC_TAG_EN
  logic [1:0]      OUT_SRC;
`endif

  tlu_fifo_arbiter #(.N_SRC(N), .MAX_BURST(4), .DW(DW)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .ENABLE(ENABLE),
    .SRC_EMPTY(SRC_EMPTY), .SRC_DATA(SRC_DATA), .SRC_PREEMPT_REQ(SRC_PREEMPT_REQ),
    .SRC_READ(SRC_READ), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
    .GRANT_IDX(GRANT_IDX), .BUSY(BUSY),
`ifdef TLU_ARB_SRC_TAG_EN
    .OUT_SRC(OUT_SRC),
`endif
    .DBG_STATE(DBG_STATE)
  );

  // Clock
  always #5 BUS_CLK = ~BUS_CLK;

  logic [DW-1:0] src_q[N][$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  logic [1:0]    got_src[$];
  int            got_cyc[$];
  int            pops[N];
  int            underflow;
  int            cycle;
  int            tests_run;
  int            tests_failed;

  function automatic logic [DW-1:0] mk(int s, int i);
    return {8'hA5, 8'(s), 8'h00, 8'(i)};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      SRC_EMPTY[i] = (src_q[i].size() == 0);
      SRC_DATA[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  // One clock: sample at the falling edge, apply pops just after the rising edge.
  task automatic step();
    logic [N-1:0] rd;
    @(negedge BUS_CLK);
    cycle++;
    rd = SRC_READ;
    if (OUT_VALID && OUT_READY) begin
      got_q.push_back(OUT_DATA);
      got_cyc.push_back(cycle);
`ifdef TLU_ARB_SRC_TAG_EN
      got_src.push_back(OUT_SRC);
`endif
    end
    @(posedge BUS_CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        else underflow++;
        pops[i]++;
      end
    end
    drive();
  endtask

  task automatic clear_sink();
    got_q.delete(); got_cyc.delete(); got_src.delete(); exp_q.delete();
  endtask

  task automatic apply_reset();
    BUS_RST_N = 1'b0;
    ENABLE = 1'b0;
    OUT_READY = 1'b1;
    SRC_PREEMPT_REQ = '0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      pops[i] = 0;
    end
    clear_sink();
    drive();
    repeat (2) @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
  endtask

  task automatic run_words(int n, int budget);
    int g = 0;
    while (got_q.size() < n && g < budget) begin
      step();
      g++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests_run++; if (SRC_READ !== 4'b0000) begin tests_failed++; $display("FAIL reset_src_read got %b want 0000", SRC_READ); end
    tests_run++; if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    tests_run++; if (OUT_DATA !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", OUT_DATA); end
    tests_run++; if (GRANT_IDX !== 2'd3) begin tests_failed++; $display("FAIL reset_grant_idx got %0d want 3", GRANT_IDX); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", BUSY); end
`ifdef TLU_ARB_SRC_TAG_EN
    tests_run++; if (OUT_SRC !== 2'd0) begin tests_failed++; $display("FAIL reset_out_src got %0d want 0", OUT_SRC); end
`endif
  endtask

  task automatic test_burst_cap();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      src_q[1].push_back(mk(1, k));
      exp_q.push_back(mk(1, k));
    end
    drive();
    ENABLE = 1'b1;
    run_words(10, 200);
    tests_run++; if (got_q.size() != 10) begin tests_failed++; $display("FAIL burst_count got %0d want 10", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 10; k++) begin
      tests_run++; if (got_q[k] !== exp_q[k]) begin tests_failed++; $display("FAIL burst_word[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
      // Bursts of 4 separated by exactly one idle output cycle.
      tests_run++; if (got_cyc[k] - got_cyc[0] !== k + k / 4) begin tests_failed++; $display("FAIL burst_timing[%0d] got %0d want %0d", k, got_cyc[k] - got_cyc[0], k + k / 4); end
`ifdef TLU_ARB_SRC_TAG_EN
      tests_run++; if (got_src[k] !== got_q[k][17:16]) begin tests_failed++; $display("FAIL burst_tag[%0d] got %0d want %0d", k, got_src[k], got_q[k][17:16]); end
`endif
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < 2; k++) begin
        src_q[s].push_back(mk(s, k));
        exp_q.push_back(mk(s, k));
      end
    end
    drive();
    ENABLE = 1'b1;
    run_words(8, 200);
    tests_run++; if (got_q.size() != 8) begin tests_failed++; $display("FAIL rr_count got %0d want 8", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 8; k++) begin
      tests_run++; if (got_q[k] !== exp_q[k]) begin tests_failed++; $display("FAIL rr_word[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
`ifdef TLU_ARB_SRC_TAG_EN
      tests_run++; if (got_src[k] !== got_q[k][17:16]) begin tests_failed++; $display("FAIL rr_tag[%0d] got %0d want %0d", k, got_src[k], got_q[k][17:16]); end
`endif
    end
  endtask

  task automatic test_preempt();
    bit armed = 1'b0;
    int g = 0;
    apply_reset();
    for (int k = 0; k < 3; k++) src_q[2].push_back(mk(2, k));
    for (int k = 0; k < 2; k++) src_q[3].push_back(mk(3, k));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(2, k));
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(0, k));
    for (int k = 0; k < 2; k++) exp_q.push_back(mk(3, k));
    drive();
    ENABLE = 1'b1;
    while (got_q.size() < 10 && g < 300) begin
      step();
      g++;
      if (!armed && pops[2] == 3) begin
        for (int k = 0; k < 5; k++) src_q[0].push_back(mk(0, k));
        SRC_PREEMPT_REQ[0] = 1'b1;
        armed = 1'b1;
        drive();
      end
      if (armed && src_q[0].size() == 0) SRC_PREEMPT_REQ[0] = 1'b0;
    end
    tests_run++; if (got_q.size() != 10) begin tests_failed++; $display("FAIL preempt_count got %0d want 10", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 10; k++) begin
      tests_run++; if (got_q[k] !== exp_q[k]) begin tests_failed++; $display("FAIL preempt_word[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
`ifdef TLU_ARB_SRC_TAG_EN
      tests_run++; if (got_src[k] !== got_q[k][17:16]) begin tests_failed++; $display("FAIL preempt_tag[%0d] got %0d want %0d", k, got_src[k], got_q[k][17:16]); end
`endif
    end
    if (got_q.size() == 10) begin
      tests_run++; if (got_cyc[7] - got_cyc[3] !== 4) begin tests_failed++; $display("FAIL preempt_uncapped got %0d want 4", got_cyc[7] - got_cyc[3]); end
    end
  endtask

  task automatic test_preempt_interrupt();
    bit armed = 1'b0;
    int g = 0;
    apply_reset();
    for (int k = 0; k < 4; k++) src_q[3].push_back(mk(3, k));
    exp_q.push_back(mk(3, 0));
    exp_q.push_back(mk(1, 0));
    for (int k = 1; k < 4; k++) exp_q.push_back(mk(3, k));
    drive();
    ENABLE = 1'b1;
    while (got_q.size() < 5 && g < 200) begin
      step();
      g++;
      if (!armed && pops[3] == 1) begin
        src_q[1].push_back(mk(1, 0));
        SRC_PREEMPT_REQ[1] = 1'b1;
        armed = 1'b1;
        drive();
      end
      if (armed && src_q[1].size() == 0) SRC_PREEMPT_REQ[1] = 1'b0;
    end
    tests_run++; if (got_q.size() != 5) begin tests_failed++; $display("FAIL interrupt_count got %0d want 5", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 5; k++) begin
      tests_run++; if (got_q[k] !== exp_q[k]) begin tests_failed++; $display("FAIL interrupt_word[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      src_q[1].push_back(mk(1, k));
      exp_q.push_back(mk(1, k));
    end
    drive();
    ENABLE = 1'b1;
    run_words(2, 100);
    OUT_READY = 1'b0;
    tests_run++; if (OUT_DATA !== mk(1, 2)) begin tests_failed++; $display("FAIL stall_held got %h want %h", OUT_DATA, mk(1, 2)); end
    for (int c = 0; c < 7; c++) begin
      step();
      tests_run++; if (OUT_VALID !== 1'b1) begin tests_failed++; $display("FAIL stall_valid[%0d] got %b want 1", c, OUT_VALID); end
      tests_run++; if (OUT_DATA !== mk(1, 2)) begin tests_failed++; $display("FAIL stall_data[%0d] got %h want %h", c, OUT_DATA, mk(1, 2)); end
      tests_run++; if (SRC_READ !== 4'b0000) begin tests_failed++; $display("FAIL stall_read[%0d] got %b want 0000", c, SRC_READ); end
    end
    OUT_READY = 1'b1;
    run_words(6, 100);
    tests_run++; if (got_q.size() != 6) begin tests_failed++; $display("FAIL stall_count got %0d want 6", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 6; k++) begin
      tests_run++; if (got_q[k] !== exp_q[k]) begin tests_failed++; $display("FAIL stall_word[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_async_reset();
    int g = 0;
    apply_reset();
    for (int k = 0; k < 8; k++) src_q[1].push_back(mk(1, k));
    drive();
    ENABLE = 1'b1;
    while (pops[1] < 3 && g < 100) begin
      step();
      g++;
    end
    #2;
    BUS_RST_N = 1'b0;
    #1;
    tests_run++; if (SRC_READ !== 4'b0000) begin tests_failed++; $display("FAIL arst_src_read got %b want 0000", SRC_READ); end
    tests_run++; if (OUT_VALID !== 1'b0) begin tests_failed++; $display("FAIL arst_out_valid got %b want 0", OUT_VALID); end
    tests_run++; if (OUT_DATA !== 32'h0) begin tests_failed++; $display("FAIL arst_out_data got %h want 0", OUT_DATA); end
    tests_run++; if (GRANT_IDX !== 2'd3) begin tests_failed++; $display("FAIL arst_grant_idx got %0d want 3", GRANT_IDX); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL arst_busy got %b want 0", BUSY); end
    step();
    clear_sink();
    for (int k = 3; k < 8; k++) exp_q.push_back(mk(1, k));
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    run_words(5, 100);
    tests_run++; if (got_q.size() != 5) begin tests_failed++; $display("FAIL arst_count got %0d want 5", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 5; k++) begin
      tests_run++; if (got_q[k] !== exp_q[k]) begin tests_failed++; $display("FAIL arst_word[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      src_q[2].push_back(mk(2, k));
      exp_q.push_back(mk(2, k));
    end
    drive();
    repeat (6) step();
    tests_run++; if (pops[2] != 0) begin tests_failed++; $display("FAIL enable_low_pops got %0d want 0", pops[2]); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL enable_low_busy got %b want 0", BUSY); end
    ENABLE = 1'b1;
    run_words(2, 100);
    tests_run++; if (got_q.size() != 2) begin tests_failed++; $display("FAIL enable_count got %0d want 2", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 2; k++) begin
      tests_run++; if (got_q[k] !== exp_q[k]) begin tests_failed++; $display("FAIL enable_word[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    underflow = 0;
    cycle = 0;
    test_reset();
    test_burst_cap();
    test_round_robin();
    test_preempt();
    test_preempt_interrupt();
    test_stall();
    test_async_reset();
    test_enable();
    tests_run++; if (underflow != 0) begin tests_failed++; $display("FAIL underflow_pops got %0d want 0", underflow); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
